mealy_seq_detect: RTL

MEALY_SEQ_DETECT -- requirements
Module: mealy_seq_detect

---
 rtl/mealy_seq_pkg.sv | 9 +
 rtl/sat_counter.sv | 19 +
 rtl/mealy_seq_detect.sv | 73 +++++++
 3 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared constants for the Mealy serial pattern detector: detection modes and
// the supported pattern-length range.
package mealy_seq_pkg;
    localparam logic OVERLAP     = 1'b1;
    localparam logic NON_OVERLAP = 1'b0;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a synchronous clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/mealy_seq_detect.sv
// Zero-latency serial pattern detector: z flags a match in the same cycle the
// last pattern bit is presented, with overlapping or non-overlapping modes.
module mealy_seq_detect
    import mealy_seq_pkg::*;
#(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0101,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat,  pat_d;
    logic [PAT_W-2:0]  hist, hist_d;
    logic [FILL_W-1:0] fill, fill_d;
    logic [FILL_W-1:0] fill_v;
    logic [PAT_W-1:0]  window;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat  <= PATTERN;
            hist <= '0;
            fill <= '0;
        end else begin
            pat  <= pat_d;
            hist <= hist_d;
            fill <= fill_d;
        end
    end

    always_comb begin
        pat_d  = pat;
        hist_d = hist;
        fill_d = fill;
        z      = 1'b0;
        // Out-of-range fill can only come from corruption; restart the fill.
        fill_v = (fill > FILL_MAX) ? '0 : fill;
        window = {hist, x};
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            z      = !rst && (fill_v == FILL_MAX) && (window == pat);
            hist_d = window[PAT_W-2:0];
            if (z && (overlap == NON_OVERLAP))
                fill_d = '0;
            else if (fill_v == FILL_MAX)
                fill_d = FILL_MAX;
            else
                fill_d = fill_v + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (z),
        .clr (cnt_clr),
        .q   (match_cnt)
    );
endmodule
